// File: rtl/bp_feedback_if.sv
// Fetch/resolve/PHT-update signal bundle for bp_feedback; slave = the feedback unit.
// Zero-latency lookup fields, one-cycle registered update fields; backpressure is fetch_stall.
interface bp_feedback_if #(
    parameter int IWIDTH = 6,
    parameter int DEPTH  = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic              en;
    logic              fetch_branch;
    logic [31:0]       fetch_pc;
    logic              pht_pred;
    logic              lookup_valid;
    logic [IWIDTH-1:0] lookup_index;
    logic              fetch_stall;
    logic              resolve_valid;
    logic              resolve_taken;
    logic              upd_valid;
    logic [IWIDTH-1:0] upd_index;
    logic              upd_taken;
    logic              mispredict;
    logic [IWIDTH-1:0] ghr;
    logic [CW-1:0]     count;

    modport slave (
        input  en, fetch_branch, fetch_pc, pht_pred, resolve_valid, resolve_taken,
        output lookup_valid, lookup_index, fetch_stall, upd_valid, upd_index,
               upd_taken, mispredict, ghr, count
    );

    modport master (
        output en, fetch_branch, fetch_pc, pht_pred, resolve_valid, resolve_taken,
        input  lookup_valid, lookup_index, fetch_stall, upd_valid, upd_index,
               upd_taken, mispredict, ghr, count
    );
endinterface

// File: rtl/bp_feedback.sv
// Branch-predictor feedback: PHT index gen, in-order in-flight queue, GHR repair (BP_GSHARE_EN enables gshare).
// Lookup is combinational; update/mispredict are registered one cycle after resolve.
// Backpressure: fetch_stall when the queue is full; a same-cycle pop does not lift full.
module bp_feedback #(
    parameter int IWIDTH = 6,
    parameter int DEPTH  = 4
) (
    input  logic          clk,
    input  logic          reset,
    bp_feedback_if.slave  bp
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [CW-1:0]     count_q, count_d;
    logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
    logic [IWIDTH-1:0] idx_q [DEPTH];
    logic [IWIDTH-1:0] idx_d [DEPTH];
    logic [DEPTH-1:0]  pred_q, pred_d;
    logic              upd_valid_q, upd_valid_d;
    logic [IWIDTH-1:0] upd_index_q, upd_index_d;
    logic              upd_taken_q, upd_taken_d;
    logic              mispredict_q, mispredict_d;
    logic [IWIDTH-1:0] ghr_w;
    logic              full, nonempty, flush, push, pop;
    logic              unused_pc;

`ifdef BP_GSHARE_EN
    logic [IWIDTH-1:0] ghr_q, ghr_d;
    logic [IWIDTH-1:0] snap_q [DEPTH];
    logic [IWIDTH-1:0] snap_d [DEPTH];
    assign ghr_w = ghr_q;
`else
    assign ghr_w = '0;
`endif

    assign unused_pc = ^{bp.fetch_pc[31:IWIDTH+2], bp.fetch_pc[1:0]};

    assign full     = (count_q == CW'(DEPTH));
    assign nonempty = (count_q != '0);
    assign flush    = bp.resolve_valid && nonempty && (pred_q[head_q] != bp.resolve_taken);
    assign push     = bp.en && bp.fetch_branch && !full && !flush;
    assign pop      = bp.en && bp.resolve_valid && nonempty;

    assign bp.lookup_index = bp.fetch_pc[IWIDTH+1:2] ^ ghr_w;
    assign bp.lookup_valid = push;
    assign bp.fetch_stall  = bp.fetch_branch && full;
    assign bp.upd_valid    = upd_valid_q;
    assign bp.upd_index    = upd_index_q;
    assign bp.upd_taken    = upd_taken_q;
    assign bp.mispredict   = mispredict_q;
    assign bp.ghr          = ghr_w;
    assign bp.count        = count_q;

    always_comb begin
        count_d      = count_q + CW'(push) - CW'(pop);
        head_d       = head_q;
        tail_d       = tail_q;
        idx_d        = idx_q;
        pred_d       = pred_q;
        upd_valid_d  = pop;
        upd_index_d  = upd_index_q;
        upd_taken_d  = upd_taken_q;
        mispredict_d = pop && flush;
`ifdef BP_GSHARE_EN
        ghr_d  = ghr_q;
        snap_d = snap_q;
`endif
        if (push) begin
            idx_d[tail_q]  = bp.lookup_index;
            pred_d[tail_q] = bp.pht_pred;
            tail_d         = tail_q + PW'(1);
`ifdef BP_GSHARE_EN
            snap_d[tail_q] = ghr_q;
            ghr_d          = {ghr_q[IWIDTH-2:0], bp.pht_pred};
`endif
        end
        if (pop) begin
            head_d      = head_q + PW'(1);
            upd_index_d = idx_q[head_q];
            upd_taken_d = bp.resolve_taken;
        end
        // Mispredict: squash everything younger and rebuild history from the resolved branch.
        if (pop && flush) begin
            count_d = '0;
            head_d  = tail_q;
`ifdef BP_GSHARE_EN
            ghr_d   = {snap_q[head_q][IWIDTH-2:0], bp.resolve_taken};
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q      <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            pred_q       <= '0;
            upd_valid_q  <= 1'b0;
            upd_index_q  <= '0;
            upd_taken_q  <= 1'b0;
            mispredict_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                idx_q[i] <= '0;
`ifdef BP_GSHARE_EN
                snap_q[i] <= '0;
`endif
            end
`ifdef BP_GSHARE_EN
            ghr_q <= '0;
`endif
        end else begin
            count_q      <= count_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            idx_q        <= idx_d;
            pred_q       <= pred_d;
            upd_valid_q  <= upd_valid_d;
            upd_index_q  <= upd_index_d;
            upd_taken_q  <= upd_taken_d;
            mispredict_q <= mispredict_d;
`ifdef BP_GSHARE_EN
            snap_q <= snap_d;
            ghr_q  <= ghr_d;
`endif
        end
    end
endmodule

// File: tb/tb_bp_feedback.sv
// Directed bench for bp_feedback; expectations adapt to whether BP_GSHARE_EN is defined.
module tb_bp_feedback;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

`ifdef BP_GSHARE_EN
    localparam bit GSH = 1'b1;
`else
    localparam bit GSH = 1'b0;
`endif

    bp_feedback_if #(.IWIDTH(6), .DEPTH(4)) bp ();

    bp_feedback #(.IWIDTH(6), .DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bp    (bp)
    );

    always #5 clk = ~clk;

    // History-dependent value: present only with gshare indexing.
    function automatic logic [31:0] g(input logic [31:0] x);
        return GSH ? x : 32'd0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic e, input logic fb, input logic [31:0] pc,
                         input logic pr, input logic rv, input logic rt);
        bp.en            = e;
        bp.fetch_branch  = fb;
        bp.fetch_pc      = pc;
        bp.pht_pred      = pr;
        bp.resolve_valid = rv;
        bp.resolve_taken = rt;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        clk      = 1'b0;
        reset    = 1'b0;
        drive(1, 0, 32'h0, 0, 0, 0);
        #2;
        chk("rst_count",    32'(bp.count), 0);
        chk("rst_ghr",      32'(bp.ghr), 0);
        chk("rst_upd_vld",  32'(bp.upd_valid), 0);
        chk("rst_upd_idx",  32'(bp.upd_index), 0);
        chk("rst_upd_tkn",  32'(bp.upd_taken), 0);
        chk("rst_mispred",  32'(bp.mispredict), 0);
        #10 reset = 1'b1;
        tick();

        // first lookup
        drive(1, 1, 32'h104, 1, 0, 0);
        #1;
        chk("s1_lv",  32'(bp.lookup_valid), 1);
        chk("s1_idx", 32'(bp.lookup_index), 32'h01);
        chk("s1_stall", 32'(bp.fetch_stall), 0);
        tick();
        chk("s1_ghr",   32'(bp.ghr), g(32'h01));
        chk("s1_count", 32'(bp.count), 1);

        // correct resolve
        drive(1, 0, 32'h0, 0, 1, 1);
        tick();
        chk("s2_upd_vld", 32'(bp.upd_valid), 1);
        chk("s2_upd_idx", 32'(bp.upd_index), 32'h01);
        chk("s2_upd_tkn", 32'(bp.upd_taken), 1);
        chk("s2_mispred", 32'(bp.mispredict), 0);
        chk("s2_count",   32'(bp.count), 0);
        drive(1, 0, 32'h0, 0, 0, 0);
        tick();
        chk("s3_upd_pulse", 32'(bp.upd_valid), 0);

        // push at 0x108 then resolve taken
        drive(1, 1, 32'h108, 1, 0, 0);
        #1;
        chk("s4_idx", 32'(bp.lookup_index), GSH ? 32'h03 : 32'h02);
        tick();
        chk("s4_ghr", 32'(bp.ghr), g(32'h03));
        drive(1, 0, 32'h0, 0, 1, 1);
        tick();
        chk("s5_upd_vld", 32'(bp.upd_valid), 1);
        chk("s5_upd_idx", 32'(bp.upd_index), GSH ? 32'h03 : 32'h02);
        chk("s5_mispred", 32'(bp.mispredict), 0);

        // fill the queue: preds 1,0,1,1
        drive(1, 1, 32'h100, 1, 0, 0); tick();
        drive(1, 1, 32'h104, 0, 0, 0); tick();
        drive(1, 1, 32'h108, 1, 0, 0); tick();
        drive(1, 1, 32'h10C, 1, 0, 0); tick();
        chk("s6_count", 32'(bp.count), 4);
        chk("s6_ghr",   32'(bp.ghr), g(32'h3B));

        // full: a pop in the same cycle does not admit the fifth branch
        drive(1, 1, 32'h110, 1, 1, 1);
        #1;
        chk("s7_stall", 32'(bp.fetch_stall), 1);
        chk("s7_lv",    32'(bp.lookup_valid), 0);
        tick();
        chk("s7_count",   32'(bp.count), 3);
        chk("s7_upd_idx", 32'(bp.upd_index), GSH ? 32'h03 : 32'h00);
        chk("s7_ghr",     32'(bp.ghr), g(32'h3B));

        // head predicted not-taken, resolves taken: flush and drop push
        drive(1, 1, 32'h114, 1, 1, 1);
        #1;
        chk("s8_lv", 32'(bp.lookup_valid), 0);
        tick();
        chk("s8_mispred", 32'(bp.mispredict), 1);
        chk("s8_upd_vld", 32'(bp.upd_valid), 1);
        chk("s8_upd_idx", 32'(bp.upd_index), GSH ? 32'h06 : 32'h01);
        chk("s8_count",   32'(bp.count), 0);
        chk("s8_ghr",     32'(bp.ghr), g(32'h0F));

        // post-flush push uses repaired history
        drive(1, 1, 32'h104, 0, 0, 0);
        #1;
        chk("s9_idx", 32'(bp.lookup_index), GSH ? 32'h0E : 32'h01);
        tick();
        chk("s9_mispred", 32'(bp.mispredict), 0);
        chk("s9_count",   32'(bp.count), 1);

        // en low: everything holds
        drive(0, 1, 32'h108, 1, 1, 1);
        #1;
        chk("s10_lv", 32'(bp.lookup_valid), 0);
        tick();
        chk("s10_count",   32'(bp.count), 1);
        chk("s10_ghr",     32'(bp.ghr), g(32'h1E));
        chk("s10_upd_vld", 32'(bp.upd_valid), 0);

        drive(1, 0, 32'h0, 0, 1, 0);
        tick();
        chk("s11_upd_idx", 32'(bp.upd_index), GSH ? 32'h0E : 32'h01);
        chk("s11_upd_tkn", 32'(bp.upd_taken), 0);
        chk("s11_mispred", 32'(bp.mispredict), 0);
        chk("s11_count",   32'(bp.count), 0);

        // resolve on empty queue is ignored
        drive(1, 0, 32'h0, 0, 1, 1);
        tick();
        chk("s12_upd_vld", 32'(bp.upd_valid), 0);
        chk("s12_mispred", 32'(bp.mispredict), 0);
        chk("s12_count",   32'(bp.count), 0);
        chk("s12_ghr",     32'(bp.ghr), g(32'h1E));

        // three pushes, then push + correct resolve keeps count
        drive(1, 1, 32'h100, 1, 0, 0); tick();
        drive(1, 1, 32'h100, 1, 0, 0); tick();
        drive(1, 1, 32'h100, 1, 0, 0); tick();
        drive(1, 1, 32'h100, 1, 1, 1); tick();
        chk("s13_count",   32'(bp.count), 3);
        chk("s13_upd_vld", 32'(bp.upd_valid), 1);
        chk("s13_ghr",     32'(bp.ghr), g(32'h2F));
        drive(1, 0, 32'h0, 0, 0, 0);
        #2 reset = 1'b0;
        #1;
        chk("s13_rst_count",   32'(bp.count), 0);
        chk("s13_rst_ghr",     32'(bp.ghr), 0);
        chk("s13_rst_upd_vld", 32'(bp.upd_valid), 0);
        #3 reset = 1'b1;
        drive(1, 0, 32'h0, 0, 1, 1);
        tick();
        chk("s13_post_upd_vld", 32'(bp.upd_valid), 0);
        chk("s13_post_count",   32'(bp.count), 0);

        // two taken predictions from ghr=0, oldest resolves not-taken
        drive(1, 1, 32'h100, 1, 0, 0); tick();
        drive(1, 1, 32'h100, 1, 0, 0); tick();
        chk("s14_ghr_pre", 32'(bp.ghr), g(32'h03));
        drive(1, 1, 32'h104, 1, 1, 0);
        #1;
        chk("s14_lv", 32'(bp.lookup_valid), 0);
        tick();
        chk("s14_mispred", 32'(bp.mispredict), 1);
        chk("s14_count",   32'(bp.count), 0);
        chk("s14_ghr",     32'(bp.ghr), 0);
        chk("s14_upd_idx", 32'(bp.upd_index), 0);
        chk("s14_upd_tkn", 32'(bp.upd_taken), 0);
        drive(1, 0, 32'h0, 0, 0, 0);
        tick();
        chk("s14_mispred_pulse", 32'(bp.mispredict), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
